// File: rtl/mem_handshake_ram_pkg.sv
// Shared types and constants for the MAR/MDR handshake memory.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DEPTH  = 256;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BYTE_W = 8;
  localparam int unsigned MEM_LANES  = 4;
  localparam int unsigned MEM_CNT_W  = 4;

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_HALF = 2'b01;
  localparam logic [1:0] DT_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Request captured on the accept edge; used for the whole access.
  typedef struct packed {
    logic                  rw;
    logic [1:0]            dt;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  // Word and the reserved encoding both behave as a 4-byte access.
  function automatic logic dt_is_wide(input logic [1:0] dt);
    return dt[1];
  endfunction

endpackage

// File: rtl/mem_handshake_ram_if.sv
// Control-unit <-> memory handshake bus (MFA/MOC plus MAR/MDR data).
interface mem_handshake_ram_if;
  import mem_pkg::*;

  logic                  MFA;
  logic                  RW;
  logic [1:0]            DT;
  logic [MEM_ADDR_W-1:0] A;
  logic [MEM_DATA_W-1:0] DataIn;
  logic [MEM_DATA_W-1:0] DataOut;
  logic                  MOC;
  logic                  FAULT;

  modport master (
    output MFA, RW, DT, A, DataIn,
    input  DataOut, MOC, FAULT
  );

  modport slave (
    input  MFA, RW, DT, A, DataIn,
    output DataOut, MOC, FAULT
  );

endinterface

// File: rtl/mem_handshake_ram_lane_align.sv
// Address alignment / misalignment detection and big-endian byte-lane steering.
// Build option: ALIGN_FAULT_EN turns misaligned accesses into faults instead
// of silently masking the low address bits.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]                           i_dt,
  input  logic [MEM_ADDR_W-1:0]                i_addr,
  input  logic [MEM_DATA_W-1:0]                i_wdata,
  input  logic [MEM_LANES-1:0][MEM_BYTE_W-1:0] i_rbyte,
  output logic [MEM_ADDR_W-1:0]                o_base,
  output logic                                 o_fault,
  output logic [MEM_LANES-1:0]                 o_lane_en,
  output logic [MEM_LANES-1:0][MEM_BYTE_W-1:0] o_wbyte,
  output logic [MEM_DATA_W-1:0]                o_rdata
);

  // Base address of the access and misalignment fault.
  always_comb begin
    o_base  = i_addr;
    o_fault = 1'b0;
`ifdef ALIGN_FAULT_EN
    if (dt_is_wide(i_dt)) begin
      o_fault = (i_addr[1:0] != 2'b00);
    end else if (i_dt == DT_HALF) begin
      o_fault = i_addr[0];
    end
`else
    if (dt_is_wide(i_dt)) begin
      o_base = {i_addr[MEM_ADDR_W-1:2], 2'b00};
    end else if (i_dt == DT_HALF) begin
      o_base = {i_addr[MEM_ADDR_W-1:1], 1'b0};
    end
`endif
  end

  // Lane k maps to address base+k; MSB of the datum sits in lane 0.
  always_comb begin
    o_lane_en = '0;
    o_wbyte   = '0;
    o_rdata   = '0;
    if (dt_is_wide(i_dt)) begin
      o_lane_en  = 4'b1111;
      o_wbyte[0] = i_wdata[31:24];
      o_wbyte[1] = i_wdata[23:16];
      o_wbyte[2] = i_wdata[15:8];
      o_wbyte[3] = i_wdata[7:0];
      o_rdata    = {i_rbyte[0], i_rbyte[1], i_rbyte[2], i_rbyte[3]};
    end else if (i_dt == DT_HALF) begin
      o_lane_en  = 4'b0011;
      o_wbyte[0] = i_wdata[15:8];
      o_wbyte[1] = i_wdata[7:0];
      o_rdata    = {16'h0000, i_rbyte[0], i_rbyte[1]};
    end else begin
      o_lane_en  = 4'b0001;
      o_wbyte[0] = i_wdata[7:0];
      o_rdata    = {24'h000000, i_rbyte[0]};
    end
  end

endmodule

// File: rtl/mem_handshake_ram.sv
// 256-byte big-endian memory with MFA/MOC handshake and fixed access latency.
// Build option: ALIGN_FAULT_EN reports misaligned half/word accesses on FAULT
// (no array access) instead of masking the low address bits.
module mem_handshake_ram
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic CLK,
  input  logic CLR,
  mem_handshake_ram_if.slave bus
);

  state_e                              r_state, w_state_nxt;
  logic [MEM_CNT_W-1:0]                r_cnt, w_cnt_nxt;
  mem_req_t                            r_req, w_req_nxt;
  logic                                r_moc, w_moc_nxt;
  logic                                r_fault, w_fault_nxt;
  logic [MEM_DATA_W-1:0]               r_dout, w_dout_nxt;
  logic [MEM_BYTE_W-1:0]               r_mem [MEM_DEPTH];

  logic                                w_access;
  logic                                w_mem_we;
  logic [MEM_ADDR_W-1:0]               w_base;
  logic                                w_fault;
  logic [MEM_LANES-1:0]                w_lane_en;
  logic [MEM_LANES-1:0][MEM_BYTE_W-1:0] w_wbyte;
  logic [MEM_LANES-1:0][MEM_BYTE_W-1:0] w_rbyte;
  logic [MEM_DATA_W-1:0]               w_rdata;

  mem_lane_align u_lane_align (
    .i_dt      (r_req.dt),
    .i_addr    (r_req.addr),
    .i_wdata   (r_req.wdata),
    .i_rbyte   (w_rbyte),
    .o_base    (w_base),
    .o_fault   (w_fault),
    .o_lane_en (w_lane_en),
    .o_wbyte   (w_wbyte),
    .o_rdata   (w_rdata)
  );

  assign w_access = (r_state == S_BUSY) && (r_cnt == '0);
  assign w_mem_we = w_access && !r_req.rw && !w_fault;

  // Gather the four candidate read bytes starting at the aligned base.
  always_comb begin
    for (int k = 0; k < int'(MEM_LANES); k++) begin
      w_rbyte[k] = r_mem[w_base + MEM_ADDR_W'(k)];
    end
  end

  // Next-state, counter and output-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_moc_nxt   = r_moc;
    w_fault_nxt = r_fault;
    w_dout_nxt  = r_dout;
    case (r_state)
      S_IDLE: begin
        if (bus.MFA) begin
          w_req_nxt   = '{rw: bus.RW, dt: bus.DT, addr: bus.A, wdata: bus.DataIn};
          w_cnt_nxt   = MEM_CNT_W'(LATENCY - 1);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_moc_nxt   = 1'b1;
          w_fault_nxt = w_fault;
          if (r_req.rw && !w_fault) begin
            w_dout_nxt = w_rdata;
          end
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - MEM_CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!bus.MFA) begin
          w_moc_nxt   = 1'b0;
          w_fault_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_moc   <= 1'b0;
      r_fault <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_moc   <= w_moc_nxt;
      r_fault <= w_fault_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // Storage array: not reset; written only on the completion edge of a write.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int k = 0; k < int'(MEM_LANES); k++) begin
        if (w_lane_en[k]) begin
          r_mem[w_base + MEM_ADDR_W'(k)] <= w_wbyte[k];
        end
      end
    end
  end

  assign bus.DataOut = r_dout;
  assign bus.MOC     = r_moc;
  assign bus.FAULT   = r_fault;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Directed bench for mem_handshake_ram (LATENCY=2); honours ALIGN_FAULT_EN.
module tb_mem_handshake_ram;

  localparam logic [1:0] T_BYTE = 2'b00;
  localparam logic [1:0] T_HALF = 2'b01;
  localparam logic [1:0] T_WORD = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

`ifdef ALIGN_FAULT_EN
  localparam logic [31:0] EXP_MIS_WORD  = 32'h11223344;
  localparam logic [31:0] EXP_MIS_FLT   = 32'd1;
  localparam logic [31:0] EXP_MIS_HALF  = 32'h11223344;
  localparam logic [31:0] EXP_MIS_WRITE = 32'h5566ABCD;
`else
  localparam logic [31:0] EXP_MIS_WORD  = 32'hCAFEF00D;
  localparam logic [31:0] EXP_MIS_FLT   = 32'd0;
  localparam logic [31:0] EXP_MIS_HALF  = 32'h00001122;
  localparam logic [31:0] EXP_MIS_WRITE = 32'h9999ABCD;
`endif

  logic clk;
  logic clr;
  int   total;
  int   bad;
  int   lat;

  mem_handshake_ram_if bus ();

  mem_handshake_ram #(.LATENCY(2)) u_dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at negedge; returns 1 time unit after the accept edge.
  task automatic req_start(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    bus.MFA = 1'b1; bus.RW = rw; bus.DT = dt; bus.A = a; bus.DataIn = wd;
    @(posedge clk);
    #1;
  endtask

  // Count edges after the accept edge until MOC is seen (bounded).
  task automatic wait_moc(output int edges);
    edges = 0;
    while (bus.MOC !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic do_op(input logic rw, input logic [1:0] dt, input logic [7:0] a,
                       input logic [31:0] wd, output int edges);
    req_start(rw, dt, a, wd);
    wait_moc(edges);
  endtask

  // Drop MFA; MOC must fall on the next edge.
  task automatic finish_op(input string tag);
    @(negedge clk);
    bus.MFA = 1'b0;
    @(posedge clk);
    #1;
    check(tag, 32'(bus.MOC), 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; lat = 0;
    clr = 1'b0;
    bus.MFA = 1'b0; bus.RW = 1'b1; bus.DT = T_BYTE; bus.A = 8'h00; bus.DataIn = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_moc",   32'(bus.MOC),   32'd0);
    check("rst_fault", 32'(bus.FAULT), 32'd0);
    check("rst_dout",  bus.DataOut,    32'd0);
    @(negedge clk) clr = 1'b1;

    // Preload known contents.
    do_op(1'b0, T_WORD, 8'h10, 32'hCAFEF00D, lat);
    check("pre_lat", 32'(lat), 32'd2);
    finish_op("pre_rel");
    do_op(1'b0, T_WORD, 8'h30, 32'h0BADC0DE, lat);
    finish_op("pre30_rel");
    do_op(1'b0, T_WORD, 8'h04, 32'h55667788, lat);
    finish_op("pre04_rel");
    do_op(1'b1, T_WORD, 8'h10, 32'h0, lat);
    check("pre_rd10", bus.DataOut, 32'hCAFEF00D);
    finish_op("pre_rd_rel");

    // Reset in the middle of a write aborts it.
    req_start(1'b0, T_WORD, 8'h10, 32'hDEADBEEF);
    clr = 1'b0;
    #1;
    check("t1_moc",  32'(bus.MOC), 32'd0);
    check("t1_dout", bus.DataOut,  32'd0);
    bus.MFA = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    do_op(1'b1, T_WORD, 8'h10, 32'h0, lat);
    check("t1_old", bus.DataOut, 32'hCAFEF00D);
    finish_op("t1_rel");

    // Word write then byte read, latency on both.
    do_op(1'b0, T_WORD, 8'h20, 32'h11223344, lat);
    check("t2_wlat", 32'(lat), 32'd2);
    finish_op("t2_wrel");
    do_op(1'b1, T_BYTE, 8'h21, 32'h0, lat);
    check("t2_rlat", 32'(lat), 32'd2);
    check("t2_byte", bus.DataOut, 32'h00000022);
    finish_op("t2_rrel");

    // Halfword write into the low half of a word.
    do_op(1'b0, T_HALF, 8'h06, 32'h0000ABCD, lat);
    finish_op("t3_wrel");
    do_op(1'b1, T_WORD, 8'h04, 32'h0, lat);
    check("t3_word", bus.DataOut, 32'h5566ABCD);
    finish_op("t3_rrel");

    // MFA held high after MOC: MOC stays up, data stable.
    do_op(1'b1, T_WORD, 8'h20, 32'h0, lat);
    check("t4_data", bus.DataOut, 32'h11223344);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t4_hold_moc",  32'(bus.MOC), 32'd1);
      check("t4_hold_data", bus.DataOut,  32'h11223344);
    end
    finish_op("t4_rel");
    check("t4_fault", 32'(bus.FAULT), 32'd0);

    // Misaligned accesses: masked or faulted depending on build.
    do_op(1'b1, T_WORD, 8'h13, 32'h0, lat);
    check("t5_lat",   32'(lat),        32'd2);
    check("t5_data",  bus.DataOut,     EXP_MIS_WORD);
    check("t5_fault", 32'(bus.FAULT),  EXP_MIS_FLT);
    finish_op("t5_rel");
    check("t5_fault_clr", 32'(bus.FAULT), 32'd0);
    do_op(1'b1, T_HALF, 8'h21, 32'h0, lat);
    check("t5_half",   bus.DataOut,    EXP_MIS_HALF);
    check("t5_hfault", 32'(bus.FAULT), EXP_MIS_FLT);
    finish_op("t5_hrel");
    do_op(1'b0, T_HALF, 8'h05, 32'h00009999, lat);
    finish_op("t5_wrel");
    do_op(1'b1, T_WORD, 8'h04, 32'h0, lat);
    check("t5_wchk", bus.DataOut, EXP_MIS_WRITE);
    finish_op("t5_wchk_rel");

    // Reserved size code behaves as a word.
    do_op(1'b1, T_RSVD, 8'h20, 32'h0, lat);
    check("rsvd_word", bus.DataOut, 32'h11223344);
    finish_op("rsvd_rel");

    // Top-of-memory word and byte lanes.
    do_op(1'b0, T_WORD, 8'hFC, 32'h01020304, lat);
    finish_op("top_w_rel");
    do_op(1'b0, T_BYTE, 8'hFF, 32'hFFFFFF7E, lat);
    finish_op("top_b_rel");
    do_op(1'b1, T_WORD, 8'hFC, 32'h0, lat);
    check("top_word", bus.DataOut, 32'h0102037E);
    finish_op("top_r_rel");

    // Inputs changed during BUSY are ignored.
    req_start(1'b1, T_WORD, 8'h20, 32'h0);
    bus.RW = 1'b0; bus.A = 8'h30; bus.DataIn = 32'hFFFFFFFF;
    wait_moc(lat);
    check("t6_lat",  32'(lat),     32'd2);
    check("t6_data", bus.DataOut,  32'h11223344);
    finish_op("t6_rel");
    bus.RW = 1'b1;
    do_op(1'b1, T_WORD, 8'h30, 32'h0, lat);
    check("t6_30", bus.DataOut, 32'h0BADC0DE);
    finish_op("t6_30_rel");

    // MFA dropped during BUSY: op still completes, DONE exits next edge.
    req_start(1'b1, T_BYTE, 8'h22, 32'h0);
    bus.MFA = 1'b0;
    wait_moc(lat);
    check("drop_lat",  32'(lat),    32'd2);
    check("drop_data", bus.DataOut, 32'h00000033);
    @(posedge clk);
    #1;
    check("drop_moc", 32'(bus.MOC), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
